ttt_game_engine: RTL and testbench

- Sequential successor to the combinational move checker. Holds an N x N two-player board and accepts one move per handshake.
- Validates each move, commits legal moves to the board, and detects K-in-a-row wins and draws.
- Tracks whose turn it is and enforces an optional per-turn timeout.
- Sits between the keypad/move-entry front end and the display/score logic.

---
 rtl/ttt_game_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_ttt_game_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ttt_game_engine                                                          |
// | N x N two-player board engine: move validation, commit, K-in-a-row win   |
// | and draw detection, turn tracking and optional per-turn timeout.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ttt_game_engine #(
  parameter int N       = 3,
  parameter int K       = 3,
  parameter int TIMEOUT = 0,
  parameter int IW      = $clog2(N*N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            new_game,
  input  logic            move_valid,
  input  logic [IW-1:0]   move_idx,
  output logic            move_ready,
  output logic            move_ack,
  output logic            move_err,
  output logic [2:0]      err_code,
  output logic [1:0]      turn,
  output logic [1:0]      state,
  output logic [N*N-1:0]  board_a,
  output logic [N*N-1:0]  board_b,
  output logic            timeout
);

  localparam int C  = N * N;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TW-1:0] c_tlast = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [IW:0]   c_cells = (IW+1)'(C);

  localparam logic [1:0] c_wait = 2'd0;
  localparam logic [1:0] c_eval = 2'd1;
  localparam logic [1:0] c_over = 2'd2;

  localparam logic [1:0] c_pa = 2'b01;
  localparam logic [1:0] c_pb = 2'b10;

  localparam logic [1:0] c_play = 2'b00;
  localparam logic [1:0] c_awin = 2'b01;
  localparam logic [1:0] c_bwin = 2'b10;
  localparam logic [1:0] c_draw = 2'b11;

  localparam logic [2:0] c_err_none  = 3'd0;
  localparam logic [2:0] c_err_range = 3'd1;
  localparam logic [2:0] c_err_occ   = 3'd2;
  localparam logic [2:0] c_err_over  = 3'd3;

  logic [1:0]    r_fsm;
  logic [1:0]    w_fsm_nxt;
  logic [C-1:0]  r_board_a;
  logic [C-1:0]  r_board_b;
  logic [1:0]    r_turn;
  logic [1:0]    r_state;
  logic [2:0]    r_err_code;
  logic          r_ack;
  logic          r_err;
  logic          r_timeout;
  logic [TW-1:0] r_timer;

  logic [C-1:0]   w_onehot;
  logic [C-1:0]   w_both;
  logic [C-1:0]   w_mover;
  logic           w_range_err;
  logic           w_occ;
  logic           w_legal;
  logic           w_win;
  logic           w_full;
  logic [4*C-1:0] w_hit;

  // Cell mask of the K-long window starting at (r0,c0) stepping (dr,dc).
  function automatic logic [C-1:0] f_mask(input int r0, input int c0,
                                          input int dr, input int dc);
    logic [C-1:0] m;
    m = '0;
    for (int i = 0; i < K; i++) begin
      m[(r0 + i*dr)*N + (c0 + i*dc)] = 1'b1;
    end
    return m;
  endfunction

  assign w_onehot    = {{(C-1){1'b0}}, 1'b1} << move_idx;
  assign w_both      = r_board_a | r_board_b;
  assign w_range_err = ({1'b0, move_idx} >= c_cells);
  assign w_occ       = |(w_onehot & w_both);
  assign w_legal     = !w_range_err && !w_occ;
  assign w_mover     = (r_turn == c_pa) ? r_board_a : r_board_b;
  assign w_full      = &w_both;
  assign w_win       = |w_hit;

  // One window per (start cell, direction); starts whose window leaves the board never hit.
  for (genvar d = 0; d < 4; d++) begin : g_dir
    localparam int c_dr = (d == 0) ? 0 : 1;
    localparam int c_dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
    for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
        localparam int c_re = r + (K-1)*c_dr;
        localparam int c_ce = c + (K-1)*c_dc;
        if ((c_re < N) && (c_ce >= 0) && (c_ce < N)) begin : g_fit
          localparam logic [C-1:0] c_mask = f_mask(r, c, c_dr, c_dc);
          assign w_hit[d*C + r*N + c] = ((w_mover & c_mask) == c_mask);
        end else begin : g_nofit
          assign w_hit[d*C + r*N + c] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= c_wait;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (new_game) begin
      w_fsm_nxt = c_wait;
    end else begin
      case (r_fsm)
        c_wait:  if (move_valid && w_legal) w_fsm_nxt = c_eval;
        c_eval:  w_fsm_nxt = (w_win || w_full) ? c_over : c_wait;
        c_over:  w_fsm_nxt = c_over;
        default: w_fsm_nxt = c_wait;
      endcase
    end
  end

  // The only busy cycle is the one carrying the ack, while the new board is evaluated.
  always_comb begin
    move_ready = 1'b1;
    if (r_fsm == c_eval) move_ready = 1'b0;
  end

  // A legal move is committed on its accepting edge, so ack and board land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board_a  <= '0;
      r_board_b  <= '0;
      r_turn     <= c_pa;
      r_state    <= c_play;
      r_err_code <= c_err_none;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      if (new_game) begin
        r_board_a  <= '0;
        r_board_b  <= '0;
        r_turn     <= c_pa;
        r_state    <= c_play;
        r_err_code <= c_err_none;
        r_timer    <= '0;
      end else begin
        case (r_fsm)
          c_wait: begin
            if (move_valid) begin
              if (w_range_err) begin
                r_err      <= 1'b1;
                r_err_code <= c_err_range;
              end else if (w_occ) begin
                r_err      <= 1'b1;
                r_err_code <= c_err_occ;
              end else begin
                r_ack      <= 1'b1;
                r_err_code <= c_err_none;
                if (r_turn == c_pa) r_board_a <= r_board_a | w_onehot;
                else                r_board_b <= r_board_b | w_onehot;
              end
              // A handshake on the last tick pre-empts the timeout; hold the count there.
              if ((TIMEOUT != 0) && (r_timer != c_tlast)) r_timer <= r_timer + TW'(1);
            end else if (TIMEOUT != 0) begin
              if (r_timer == c_tlast) begin
                r_timeout <= 1'b1;
                r_turn    <= ~r_turn;
                r_timer   <= '0;
              end else begin
                r_timer <= r_timer + TW'(1);
              end
            end
          end
          c_eval: begin
            if (w_win) begin
              r_state <= (r_turn == c_pa) ? c_awin : c_bwin;
            end else if (w_full) begin
              r_state <= c_draw;
            end else begin
              r_turn  <= ~r_turn;
              r_timer <= '0;
            end
          end
          c_over: begin
            if (move_valid) begin
              r_err      <= 1'b1;
              r_err_code <= c_err_over;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign move_ack = r_ack;
  assign move_err = r_err;
  assign err_code = r_err_code;
  assign turn     = r_turn;
  assign state    = r_state;
  assign board_a  = r_board_a;
  assign board_b  = r_board_b;
  assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_engine.sv
`default_nettype none
// Directed bench for ttt_game_engine: 3x3, 5x5/K=4 and 3x3 with a 10-cycle turn timeout.
module tb_ttt_game_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       mv = 1'b0;
  logic       ng = 1'b0;
  logic [4:0] mi = 5'd0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  logic        d3_rdy, d3_ack, d3_err, d3_tmo;
  logic [2:0]  d3_ec;
  logic [1:0]  d3_tn, d3_st;
  logic [8:0]  d3_ba, d3_bb;
  logic        d5_rdy, d5_ack, d5_err, d5_tmo;
  logic [2:0]  d5_ec;
  logic [1:0]  d5_tn, d5_st;
  logic [24:0] d5_ba, d5_bb;
  logic        dt_rdy, dt_ack, dt_err, dt_tmo;
  logic [2:0]  dt_ec;
  logic [1:0]  dt_tn, dt_st;
  logic [8:0]  dt_ba, dt_bb;

  ttt_game_engine #(.N(3), .K(3), .TIMEOUT(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .new_game(ng && sel == 2'd0), .move_valid(mv && sel == 2'd0),
    .move_idx(mi[3:0]), .move_ready(d3_rdy), .move_ack(d3_ack), .move_err(d3_err),
    .err_code(d3_ec), .turn(d3_tn), .state(d3_st), .board_a(d3_ba), .board_b(d3_bb),
    .timeout(d3_tmo));

  ttt_game_engine #(.N(5), .K(4), .TIMEOUT(0)) u_d5 (
    .clk(clk), .rst_n(rst_n), .new_game(ng && sel == 2'd1), .move_valid(mv && sel == 2'd1),
    .move_idx(mi[4:0]), .move_ready(d5_rdy), .move_ack(d5_ack), .move_err(d5_err),
    .err_code(d5_ec), .turn(d5_tn), .state(d5_st), .board_a(d5_ba), .board_b(d5_bb),
    .timeout(d5_tmo));

  ttt_game_engine #(.N(3), .K(3), .TIMEOUT(10)) u_dt (
    .clk(clk), .rst_n(rst_n), .new_game(ng && sel == 2'd2), .move_valid(mv && sel == 2'd2),
    .move_idx(mi[3:0]), .move_ready(dt_rdy), .move_ack(dt_ack), .move_err(dt_err),
    .err_code(dt_ec), .turn(dt_tn), .state(dt_st), .board_a(dt_ba), .board_b(dt_bb),
    .timeout(dt_tmo));

  // Observed outputs of the instance currently selected.
  logic        rdy, ack, err, tmo;
  logic [2:0]  ec;
  logic [1:0]  tn, st;
  logic [24:0] ba, bb;

  always_comb begin
    rdy = d3_rdy; ack = d3_ack; err = d3_err; tmo = d3_tmo; ec = d3_ec;
    tn = d3_tn; st = d3_st; ba = {16'd0, d3_ba}; bb = {16'd0, d3_bb};
    if (sel == 2'd1) begin
      rdy = d5_rdy; ack = d5_ack; err = d5_err; tmo = d5_tmo; ec = d5_ec;
      tn = d5_tn; st = d5_st; ba = d5_ba; bb = d5_bb;
    end else if (sel == 2'd2) begin
      rdy = dt_rdy; ack = dt_ack; err = dt_err; tmo = dt_tmo; ec = dt_ec;
      tn = dt_tn; st = dt_st; ba = {16'd0, dt_ba}; bb = {16'd0, dt_bb};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One handshake; checks the t+1 pulse and leaves the bench at t+2.
  task automatic do_move(input string tag, input int idx, input bit ok, input int code);
    mv = 1'b1;
    mi = 5'(idx);
    tick();
    mv = 1'b0;
    chk({tag, ".ack"}, 32'(ack), 32'(ok));
    chk({tag, ".err"}, 32'(err), 32'(!ok));
    chk({tag, ".code"}, 32'(ec), 32'(code));
    tick();
  endtask

  task automatic start_game();
    ng = 1'b1;
    tick();
    ng = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_win  [9] = '{0, 2, 1, 3, 4, 6, 5, 7, 8};
    int seq_5    [13] = '{0, 20, 1, 21, 2, 23, 4, 24, 8, 10, 12, 11, 16};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst.board_a", 32'(ba), 0);
    chk("rst.board_b", 32'(bb), 0);
    chk("rst.turn", 32'(tn), 1);
    chk("rst.state", 32'(st), 0);
    chk("rst.ready", 32'(rdy), 1);
    chk("rst.ack", 32'(ack), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.code", 32'(ec), 0);
    chk("rst.timeout", 32'(tmo), 0);
    tick();

    // Row win for A: 0,3,1,4,2.
    do_move("g1.m0", 0, 1'b1, 0);
    do_move("g1.m1", 3, 1'b1, 0);
    do_move("g1.m2", 1, 1'b1, 0);
    do_move("g1.m3", 4, 1'b1, 0);
    mv = 1'b1; mi = 5'd2;
    tick();
    mv = 1'b0;
    chk("g1.last.ack", 32'(ack), 1);
    chk("g1.last.ready_t1", 32'(rdy), 0);
    chk("g1.last.board_t1", 32'(ba), 32'h7);
    chk("g1.last.state_t1", 32'(st), 0);
    tick();
    chk("g1.state_t2", 32'(st), 1);
    chk("g1.ready_t2", 32'(rdy), 1);
    chk("g1.turn", 32'(tn), 1);
    do_move("g1.over", 5, 1'b0, 3);
    chk("g1.board_a", 32'(ba), 32'h7);
    chk("g1.board_b", 32'(bb), 32'h18);

    // new_game clears; occupied and out-of-range rejections.
    start_game();
    chk("ng.board_a", 32'(ba), 0);
    chk("ng.state", 32'(st), 0);
    chk("ng.turn", 32'(tn), 1);
    do_move("occ.m0", 4, 1'b1, 0);
    chk("occ.turn_b", 32'(tn), 2);
    do_move("occ.m1", 4, 1'b0, 2);
    chk("occ.board_b", 32'(bb), 0);
    chk("occ.turn", 32'(tn), 2);
    do_move("rng.m", 9, 1'b0, 1);
    tick();
    chk("rng.code_held", 32'(ec), 1);
    chk("rng.turn", 32'(tn), 2);
    repeat (20) tick();
    chk("noto.timeout", 32'(tmo), 0);
    chk("noto.turn", 32'(tn), 2);

    // Full board with no line -> draw.
    start_game();
    for (int i = 0; i < 9; i++) do_move($sformatf("draw.m%0d", i), seq_draw[i], 1'b1, 0);
    chk("draw.state", 32'(st), 3);
    chk("draw.board_a", 32'(ba), 397);
    chk("draw.board_b", 32'(bb), 114);

    // Ninth move fills the board and completes a diagonal -> win, not draw.
    start_game();
    for (int i = 0; i < 9; i++) do_move($sformatf("win9.m%0d", i), seq_win[i], 1'b1, 0);
    chk("win9.state", 32'(st), 1);
    chk("win9.board_a", 32'(ba), 307);
    chk("win9.board_b", 32'(bb), 204);

    // Async reset right after a commit leaves nothing behind.
    start_game();
    mv = 1'b1; mi = 5'd0;
    tick();
    mv = 1'b0;
    chk("arst.pre_board", 32'(ba), 1);
    rst_n = 1'b0;
    #1;
    chk("arst.board_a", 32'(ba), 0);
    chk("arst.ack", 32'(ack), 0);
    chk("arst.ready", 32'(rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 5x5, K=4: three in a row is not a win; anti-diagonal 4,8,12,16 is.
    sel = 2'd1;
    start_game();
    do_move("n5.range", 25, 1'b0, 1);
    do_move("n5.edge", 24, 1'b1, 0);
    start_game();
    for (int i = 0; i < 5; i++) do_move($sformatf("n5.m%0d", i), seq_5[i], 1'b1, 0);
    chk("n5.row3_state", 32'(st), 0);
    for (int i = 5; i < 13; i++) do_move($sformatf("n5.m%0d", i), seq_5[i], 1'b1, 0);
    chk("n5.anti_state", 32'(st), 1);
    chk("n5.board_a", 32'(ba), 32'h11117);

    // Timeout after 10 idle cycles.
    sel = 2'd2;
    start_game();
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("to.c%0d.timeout", i), 32'(tmo), (i == 10) ? 1 : 0);
      chk($sformatf("to.c%0d.turn", i), 32'(tn), (i == 10) ? 2 : 1);
    end
    tick();
    chk("to.pulse_end", 32'(tmo), 0);

    // Handshake on the last tick wins over the timeout.
    start_game();
    repeat (9) tick();
    mv = 1'b1; mi = 5'd4;
    tick();
    mv = 1'b0;
    chk("to9.ack", 32'(ack), 1);
    chk("to9.timeout", 32'(tmo), 0);
    tick();
    chk("to9.timeout_t2", 32'(tmo), 0);
    chk("to9.turn", 32'(tn), 2);
    chk("to9.board_a", 32'(ba), 32'h10);

    // new_game together with a move: board cleared, no ack or err.
    ng = 1'b1; mv = 1'b1; mi = 5'd0;
    tick();
    ng = 1'b0; mv = 1'b0;
    chk("ngmv.ack", 32'(ack), 0);
    chk("ngmv.err", 32'(err), 0);
    chk("ngmv.board_a", 32'(ba), 0);
    chk("ngmv.board_b", 32'(bb), 0);
    chk("ngmv.turn", 32'(tn), 1);
    chk("ngmv.state", 32'(st), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
